hilo_div_commit: RTL and testbench
==================================

// Module: hilo_div_commit
// PURPOSE
//  Downstream stage of the ALU divider/multiplier: captures Y_hi/Y_lo/N/Z at issue of a
//  MULT/DIV, holds them pending for a fixed latency (timing of the iterative unit), then
//  commits them to the architectural HI/LO registers. Serves MFHI/MFLO reads, stalling the
//  pipeline while a result is pending, and accepts MTHI/MTLO writes.
// PARAMETERS
//  DW       32  datapath width
//  DIV_LAT  32  cycles from DIV issue to HI/LO commit (>=2)
//  MUL_LAT  4   cycles from MULT issue to HI/LO commit (>=2)
// PORTS
//  clk       in   1   rising-edge clock, the only clock
//  reset     in   1   synchronous, active-high reset
//  start     in   1   1-cycle issue pulse for the op selected by FS
//  FS        in   5   function select; 5'h1E = MULT, 5'h1F = DIV, others ignored
//  T         in   DW  divisor operand, used only for divide-by-zero detect
//  y_hi_in   in   DW  remainder / product high word, valid in start cycle
//  y_lo_in   in   DW  quotient / product low word, valid in start cycle
//  n_in,z_in in   1   flags from the unit, valid in start cycle
//  mt_we     in   1   MTHI/MTLO write strobe
//  mt_sel    in   1   0 = LO, 1 = HI (for mt_we and mf_req)
//  mt_data   in   DW  MTHI/MTLO write data
//  mf_req    in   1   MFHI/MFLO read request
//  mf_data   out  DW  selected HI/LO value (combinational)
//  hi, lo    out  DW  architectural HI/LO registers
//  N, Z      out  1   flags of last committed op
//  busy      out  1   result pending
//  stall     out  1   mf_req & busy & ~commit, combinational
//  dz_err    out  1   1-cycle pulse: DIV issued with T == 0
//  issue_err out  1   1-cycle pulse: start accepted while busy
// BEHAVIOUR
//  - Reset (sync, high): hi, lo, pending regs = 0; N=0, Z=1; FSM IDLE; cnt=0; busy, dz_err,
//    issue_err = 0. Reset mid-operation discards the pending result; nothing commits.
//  - FSM IDLE: start & FS=1F & T!=0 -> BUSY, cnt=DIV_LAT-1; start & FS=1E -> BUSY,
//    cnt=MUL_LAT-1; y_hi_in/y_lo_in/n_in/z_in latched into pending regs in that cycle.
//  - start & FS=1F & T==0 in IDLE: dz_err=1 next cycle, stays IDLE, HI/LO/N/Z unchanged.
//  - BUSY: cnt decrements each cycle; commit = (cnt==0). On commit edge hi<=p_hi, lo<=p_lo,
//    N/Z updated, -> IDLE. busy=1 from cycle after start through commit cycle inclusive.
//  - Latency: HI/LO visible LAT cycles after the start edge.
//  - start while BUSY: ignored, issue_err pulses, pending op continues unchanged.
//  - mf_req in BUSY, cnt!=0: stall=1, mf_data undefined. In commit cycle: stall=0,
//    mf_data bypasses pending value. In IDLE: mf_data = mt_sel ? hi : lo, stall=0.
//  - mt_we in IDLE: targeted reg written next edge, other reg and N/Z kept.
//  - mt_we in BUSY: pending op aborted (-> IDLE, no commit), targeted reg written.
//  - mt_we same cycle as start (IDLE): start wins, write dropped.
//  - mt_we and mf_req same cycle: mf_data returns old value (no write-through).
// STRUCTURE
//  - Shared package: FS codes (FS_MULT=5'h1E, FS_DIV=5'h1F), state enum {IDLE,BUSY},
//    HI/LO select encodings.
//  - One sub-module: lat_counter (load value, decrement, zero flag, width $clog2(max LAT)).
//  - Top holds FSM, pending regs, HI/LO regs, read mux and bypass.
// TESTING
//  1. DIV 100/7 -> busy 32 cycles, hi=2, lo=14, N=0, Z=0 visible on cycle 32, not 31.
//  2. DIV T=0 -> dz_err pulse 1 cycle, hi/lo keep prior values, busy never asserts.
//  3. mf_req(LO) 1 cycle after DIV 9/3 -> stall high 30 cycles, commit cycle mf_data=3.
//  4. MULT then start again at cycle 2 -> issue_err pulse, commit of first op at cycle 4.
//  5. DIV issued, mt_we HI=32'hDEAD at cycle 5 -> busy drops, hi=DEAD, lo unchanged.
//  6. Reset at cycle 10 of DIV -> hi=lo=0, Z=1, busy=0; no commit at cycle 32.

Source files
------------

// File: rtl/hilo_div_commit_pkg.sv
// Shared definitions for the HI/LO commit stage: function codes, FSM states, register selects.
package hilo_div_commit_pkg;

    localparam logic [4:0] FS_MULT = 5'h1E;
    localparam logic [4:0] FS_DIV  = 5'h1F;

    // mt_sel / mf_req register select
    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    function automatic int unsigned max_lat(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hilo_div_commit_lat_counter.sv
// Down-counter timing the pending result; loads LAT-1 at issue and flags zero on the commit cycle.
module hilo_div_commit_lat_counter
    import hilo_div_commit_pkg::*;
#(
    parameter int unsigned Width = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q;

    // Load has priority over decrement; the count parks at zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - Width'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hilo_div_commit.sv
// HI/LO commit stage: holds a MULT/DIV result pending for the unit latency, then commits it;
// serves MFHI/MFLO with stall and commit-cycle bypass, and accepts MTHI/MTLO writes.
module hilo_div_commit
    import hilo_div_commit_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [4:0]    FS,
    input  logic [DW-1:0] T,
    input  logic [DW-1:0] y_hi_in,
    input  logic [DW-1:0] y_lo_in,
    input  logic          n_in,
    input  logic          z_in,
    input  logic          mt_we,
    input  logic          mt_sel,
    input  logic [DW-1:0] mt_data,
    input  logic          mf_req,
    output logic [DW-1:0] mf_data,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo,
    output logic          N,
    output logic          Z,
    output logic          busy,
    output logic          stall,
    output logic          dz_err,
    output logic          issue_err
);

    localparam int unsigned CW = $clog2(max_lat(DIV_LAT, MUL_LAT));
    localparam logic [CW-1:0] DivLoad = CW'(DIV_LAT - 1);
    localparam logic [CW-1:0] MulLoad = CW'(MUL_LAT - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DW-1:0] p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic          n_q, n_d, z_q, z_d, p_n_q, p_n_d, p_z_q, p_z_d;
    logic          dz_q, dz_d, ie_q, ie_d;
    logic          cnt_load, cnt_zero, commit;
    logic [CW-1:0] cnt_load_val;
    logic          is_mult, is_div, t_zero;

    assign is_mult = start && (FS == FS_MULT);
    assign is_div  = start && (FS == FS_DIV);
    assign t_zero  = (T == '0);
    assign commit  = (state_q == StBusy) && cnt_zero;

    hilo_div_commit_lat_counter #(
        .Width(CW)
    ) u_lat_counter (
        .clk_i     (clk),
        .reset_i   (reset),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .dec_i     (state_q == StBusy),
        .zero_o    (cnt_zero)
    );

    // Next-state: issue, commit, MT write (aborts a pending op), error pulses.
    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        n_d          = n_q;
        z_d          = z_q;
        p_hi_d       = p_hi_q;
        p_lo_d       = p_lo_q;
        p_n_d        = p_n_q;
        p_z_d        = p_z_q;
        dz_d         = 1'b0;
        ie_d         = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            StIdle: begin
                // A valid start takes priority and drops a same-cycle MT write.
                if (is_mult || (is_div && !t_zero)) begin
                    state_d      = StBusy;
                    cnt_load     = 1'b1;
                    cnt_load_val = is_div ? DivLoad : MulLoad;
                    p_hi_d       = y_hi_in;
                    p_lo_d       = y_lo_in;
                    p_n_d        = n_in;
                    p_z_d        = z_in;
                end else if (is_div) begin
                    dz_d = 1'b1;
                end else if (mt_we) begin
                    if (mt_sel == SEL_HI) hi_d = mt_data;
                    else                  lo_d = mt_data;
                end
            end
            StBusy: begin
                ie_d = is_mult || is_div;
                if (mt_we) begin
                    state_d = StIdle;
                    if (mt_sel == SEL_HI) hi_d = mt_data;
                    else                  lo_d = mt_data;
                end else if (cnt_zero) begin
                    state_d = StIdle;
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    n_d     = p_n_q;
                    z_d     = p_z_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and architectural registers; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b1;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            p_n_q   <= 1'b0;
            p_z_q   <= 1'b0;
            dz_q    <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            n_q     <= n_d;
            z_q     <= z_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            p_n_q   <= p_n_d;
            p_z_q   <= p_z_d;
            dz_q    <= dz_d;
            ie_q    <= ie_d;
        end
    end

    // MF read mux; in the commit cycle the pending value is forwarded.
    always_comb begin
        if (commit) mf_data = (mt_sel == SEL_HI) ? p_hi_q : p_lo_q;
        else        mf_data = (mt_sel == SEL_HI) ? hi_q : lo_q;
    end

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign N         = n_q;
    assign Z         = z_q;
    assign busy      = (state_q == StBusy);
    assign stall     = mf_req && busy && !commit;
    assign dz_err    = dz_q;
    assign issue_err = ie_q;

endmodule

// File: tb/tb_hilo_div_commit.sv
// Self-checking bench for hilo_div_commit: vector table, directed corner sequences and
// randomized traffic checked against a time-based reference model.
module tb_hilo_div_commit;
    import hilo_div_commit_pkg::*;

    localparam int DIV_LAT = 32;
    localparam int MUL_LAT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, n_in, z_in, mt_we, mt_sel, mf_req;
    logic [4:0]  fs;
    logic [31:0] t, y_hi_in, y_lo_in, mt_data;
    logic [31:0] mf_data, hi, lo;
    logic        n_out, z_out, busy, stall, dz_err, issue_err;

    hilo_div_commit #(
        .DW(32), .DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .FS(fs), .T(t),
        .y_hi_in(y_hi_in), .y_lo_in(y_lo_in), .n_in(n_in), .z_in(z_in),
        .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data), .mf_req(mf_req),
        .mf_data(mf_data), .hi(hi), .lo(lo), .N(n_out), .Z(z_out),
        .busy(busy), .stall(stall), .dz_err(dz_err), .issue_err(issue_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a pending op commits at an absolute edge number.
    bit          m_valid = 0;
    int          edge_no = 0;
    int          commit_at = 0;
    bit          pend = 0;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          m_n, m_z, p_n, p_z, m_dz, m_ie;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int ne;
        bit vop;
        ne   = edge_no + 1;
        vop  = start && (fs == FS_MULT || fs == FS_DIV);
        m_dz = 0;
        m_ie = 0;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_n = 0; m_z = 1; pend = 0; m_valid = 1;
        end else if (pend) begin
            m_ie = vop;
            if (mt_we) begin
                pend = 0;
                if (mt_sel) m_hi = mt_data; else m_lo = mt_data;
            end else if (ne == commit_at) begin
                m_hi = p_hi; m_lo = p_lo; m_n = p_n; m_z = p_z; pend = 0;
            end
        end else if (start && (fs == FS_MULT || (fs == FS_DIV && t != 0))) begin
            pend      = 1;
            commit_at = ne + ((fs == FS_MULT) ? MUL_LAT : DIV_LAT);
            p_hi = y_hi_in; p_lo = y_lo_in; p_n = n_in; p_z = z_in;
        end else if (start && fs == FS_DIV) begin
            m_dz = 1;
        end else if (mt_we) begin
            if (mt_sel) m_hi = mt_data; else m_lo = mt_data;
        end
        edge_no = ne;
    endtask

    // One clock: compare at negedge, model update at posedge, then clear strobes.
    task automatic tick();
        bit cn;
        @(negedge clk);
        if (m_valid) begin
            cn = pend && (edge_no + 1 == commit_at);
            chk("busy", busy, pend);
            chk("stall", stall, mf_req && pend && !cn);
            if (mf_req && !(pend && !cn))
                chk("mf_data", mf_data, cn ? (mt_sel ? p_hi : p_lo) : (mt_sel ? m_hi : m_lo));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("N", n_out, m_n);
            chk("Z", z_out, m_z);
            chk("dz_err", dz_err, m_dz);
            chk("issue_err", issue_err, m_ie);
        end
        @(posedge clk);
        model_edge();
        #1;
        reset = 0; start = 0; mt_we = 0; mf_req = 0;
    endtask

    task automatic issue(input logic [4:0] f, input logic [31:0] tv, yh, yl, input bit ni, zi);
        start = 1; fs = f; t = tv; y_hi_in = yh; y_lo_in = yl; n_in = ni; z_in = zi;
        tick();
    endtask

    typedef struct {
        bit          we;
        bit          sel;
        logic [31:0] data;
        logic [31:0] exp_mf;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nb, ns;
        logic [31:0] cap;
        reset = 1; start = 0; fs = 0; t = 0; y_hi_in = 0; y_lo_in = 0; n_in = 0; z_in = 0;
        mt_we = 0; mt_sel = 0; mt_data = 0; mf_req = 0;
        tick();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_N", n_out, 0);
        chk("rst_Z", z_out, 1);
        chk("rst_busy", busy, 0);

        // MT writes with same-cycle MF reads (read returns the old value)
        vecs[0] = '{1, 0, 32'h11111111, 32'h0,        32'h0,        32'h11111111};
        vecs[1] = '{1, 1, 32'h22222222, 32'h0,        32'h22222222, 32'h11111111};
        vecs[2] = '{0, 0, 32'h0,        32'h11111111, 32'h22222222, 32'h11111111};
        vecs[3] = '{1, 0, 32'h33333333, 32'h11111111, 32'h22222222, 32'h33333333};
        vecs[4] = '{0, 1, 32'h0,        32'h22222222, 32'h22222222, 32'h33333333};
        vecs[5] = '{1, 1, 32'hAAAA5555, 32'h22222222, 32'hAAAA5555, 32'h33333333};
        for (int i = 0; i < 6; i++) begin
            mt_we = vecs[i].we; mt_sel = vecs[i].sel; mt_data = vecs[i].data; mf_req = 1;
            #1;
            chk("tbl_mf", mf_data, vecs[i].exp_mf);
            tick();
            chk("tbl_hi", hi, vecs[i].exp_hi);
            chk("tbl_lo", lo, vecs[i].exp_lo);
        end

        // DIV 100/7: busy 32 cycles, result visible on cycle 32 not 31
        issue(FS_DIV, 7, 2, 14, 0, 0);
        nb = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy) nb++;
            if (i == 31) chk("t1_hi_early", hi, 32'hAAAA5555);
            tick();
        end
        chk("t1_busy_cycles", nb, 32);
        chk("t1_hi", hi, 2);
        chk("t1_lo", lo, 14);
        chk("t1_N", n_out, 0);
        chk("t1_Z", z_out, 0);
        chk("t1_busy_after", busy, 0);

        // DIV by zero
        issue(FS_DIV, 0, 32'h55, 32'h66, 1, 1);
        chk("t2_dz", dz_err, 1);
        chk("t2_busy", busy, 0);
        chk("t2_hi", hi, 2);
        chk("t2_lo", lo, 14);
        tick();
        chk("t2_dz_pulse", dz_err, 0);

        // DIV 9/3 with MFLO from cycle 2: 30 stall cycles, bypass in commit cycle
        issue(FS_DIV, 3, 0, 3, 0, 0);
        tick();
        ns = 0; cap = 32'hFFFFFFFF;
        for (int c = 2; c <= 32; c++) begin
            mf_req = 1; mt_sel = SEL_LO;
            #1;
            if (stall) ns++;
            else if (busy) cap = mf_data;
            tick();
        end
        chk("t3_stall_cycles", ns, 30);
        chk("t3_bypass", cap, 3);

        // MULT, second start at cycle 2 is rejected; first commits at cycle 4
        issue(FS_MULT, 0, 32'h12345678, 32'h9ABCDEF0, 1, 0);
        tick();
        issue(FS_MULT, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1);
        chk("t4_issue_err", issue_err, 1);
        tick();
        chk("t4_ie_pulse", issue_err, 0);
        chk("t4_hi_early", hi, 3 == 3 ? 32'h0 : 32'h0);
        tick();
        chk("t4_hi", hi, 32'h12345678);
        chk("t4_lo", lo, 32'h9ABCDEF0);
        chk("t4_N", n_out, 1);
        chk("t4_busy", busy, 0);

        // MTHI at cycle 5 of a DIV aborts it
        issue(FS_DIV, 1, 5, 6, 0, 1);
        repeat (4) tick();
        mt_we = 1; mt_sel = SEL_HI; mt_data = 32'hDEAD;
        tick();
        chk("t5_busy", busy, 0);
        chk("t5_hi", hi, 32'hDEAD);
        chk("t5_lo", lo, 32'h9ABCDEF0);
        repeat (30) tick();
        chk("t5_no_commit", lo, 32'h9ABCDEF0);

        // Reset at cycle 10 of a DIV
        issue(FS_DIV, 1, 7, 8, 1, 0);
        repeat (9) tick();
        reset = 1;
        tick();
        chk("t6_hi", hi, 0);
        chk("t6_lo", lo, 0);
        chk("t6_Z", z_out, 1);
        chk("t6_busy", busy, 0);
        repeat (25) tick();
        chk("t6_no_commit", lo, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(199) == 0);
            start = ($urandom_range(4) == 0);
            case ($urandom_range(3))
                0:       fs = FS_MULT;
                1, 2:    fs = FS_DIV;
                default: fs = 5'($urandom);
            endcase
            t       = ($urandom_range(3) == 0) ? 32'h0 : $urandom;
            y_hi_in = $urandom;
            y_lo_in = $urandom;
            n_in    = 1'($urandom);
            z_in    = 1'($urandom);
            mt_we   = ($urandom_range(15) == 0);
            mt_sel  = 1'($urandom);
            mt_data = $urandom;
            mf_req  = ($urandom_range(2) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
